// File: rtl/yc_config_pkg.sv
// yc_config_pkg: ycconfig cell codes and loader FSM state type
package yc_config_pkg;
  localparam int CFG_BITS = 3;
  localparam logic [2:0] CFG_SPACE = 3'b000;
  localparam logic [2:0] CFG_PLUS  = 3'b001;
  localparam logic [2:0] CFG_MINUS = 3'b010;
  localparam logic [2:0] CFG_VBAR  = 3'b011;
  localparam logic [2:0] CFG_ONE   = 3'b100;
  localparam logic [2:0] CFG_ZERO  = 3'b101;
  localparam logic [2:0] CFG_Y     = 3'b110;
  localparam logic [2:0] CFG_N     = 3'b111;
  typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_HIGH, ST_DONE} ld_state_e;
endpackage

// File: rtl/yc_phase_timer.sv
// yc_phase_timer: counts CDIV cycles per phase, flags the last cycle and rewinds
module yc_phase_timer #(
  parameter int CDIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic en,
  output logic last
);
  localparam int W = $clog2(CDIV + 1);
  logic [W-1:0] cnt;
  assign last = cnt == W'(CDIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (start) cnt <= '0;
    else if (en) cnt <= last ? '0 : cnt + 1'b1;
endmodule

// File: rtl/yc_config_loader.sv
// yc_config_loader: shifts a parallel image into a ycconfig chain MSB-first
// and captures the previous image from cbitout as readback
module yc_config_loader
  import yc_config_pkg::*;
#(
  parameter int NCELLS = 8,
  parameter int CDIV   = 2,
  localparam int NBITS = CFG_BITS * NCELLS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [NBITS-1:0] load_data,
  output logic             confclk,
  output logic             cbitin,
  input  logic             cbitout,
  output logic [NBITS-1:0] rd_data,
  output logic             done,
  output logic             busy
);
  localparam int BW = $clog2(NBITS + 1);
  ld_state_e        state, state_nx;
  logic [NBITS-2:0] tx;
  logic [NBITS-1:0] cap;
  logic [BW-1:0]    bitcnt;
  logic             accept, last, last_bit;
  yc_phase_timer #(.CDIV(CDIV)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .start(accept),
    .en   (state == ST_LOW || state == ST_HIGH),
    .last (last)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: state_nx = accept ? ST_LOW : ST_IDLE;
      ST_LOW:  state_nx = last ? ST_HIGH : ST_LOW;
      ST_HIGH: state_nx = !last ? ST_HIGH : last_bit ? ST_DONE : ST_LOW;
      default: state_nx = ST_IDLE;
    endcase
  end
  always_comb begin
    load_ready = state == ST_IDLE;
    accept     = load_ready && load_valid;
    last_bit   = bitcnt == BW'(NBITS - 1);
  end
  // tx holds only the bits not yet on cbitin; the first bit goes straight out
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      confclk <= 1'b0;
      cbitin  <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      rd_data <= '0;
      tx      <= '0;
      cap     <= '0;
      bitcnt  <= '0;
    end else begin
      confclk <= state_nx == ST_HIGH;
      done    <= state_nx == ST_DONE;
      busy    <= state_nx != ST_IDLE;
      if (accept) begin
        tx     <= load_data[NBITS-2:0];
        cbitin <= load_data[NBITS-1];
        cap    <= '0;
        bitcnt <= '0;
      end
      if (state == ST_LOW && last) cap <= {cap[NBITS-2:0], cbitout};
      if (state == ST_HIGH && last) begin
        if (last_bit) rd_data <= cap;
        else begin
          bitcnt <= bitcnt + 1'b1;
          cbitin <= tx[NBITS-2];
          tx     <= tx << 1;
        end
      end
    end
endmodule

// File: tb/tb_yc_config_loader.sv
// tb_yc_config_loader: three loaders driving modelled ycconfig chains, checked
// cycle by cycle against a transfer-timeline model
module tb_yc_config_loader;
  import yc_config_pkg::*;
  localparam int NI = 3;
  logic clk = 1'b0, rst_n = 1'b0;
  logic lv[NI], lr[NI], cc[NI], ci[NI], co[NI], dn[NI], bz[NI];
  logic [23:0] ld[NI], rd[NI], ch[NI], img[NI], old[NI], exp_rd[NI];
  logic [5:0]  rd0, rd1;
  logic [23:0] rd2;
  int k[NI], rises[NI];
  int n_tests = 0, n_fail = 0;
  function automatic int nb(input int i);
    return (i == 2) ? 24 : 6;
  endfunction
  function automatic int cd(input int i);
    return (i == 0) ? 1 : (i == 1) ? 3 : 2;
  endfunction
  function automatic logic [23:0] msk(input int i);
    return 24'((64'(1) << nb(i)) - 1);
  endfunction
  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  yc_config_loader #(.NCELLS(2), .CDIV(1)) u_a (
    .clk(clk), .rst_n(rst_n), .load_valid(lv[0]), .load_ready(lr[0]), .load_data(ld[0][5:0]),
    .confclk(cc[0]), .cbitin(ci[0]), .cbitout(co[0]), .rd_data(rd0), .done(dn[0]), .busy(bz[0]));
  yc_config_loader #(.NCELLS(2), .CDIV(3)) u_b (
    .clk(clk), .rst_n(rst_n), .load_valid(lv[1]), .load_ready(lr[1]), .load_data(ld[1][5:0]),
    .confclk(cc[1]), .cbitin(ci[1]), .cbitout(co[1]), .rd_data(rd1), .done(dn[1]), .busy(bz[1]));
  yc_config_loader #(.NCELLS(8), .CDIV(2)) u_c (
    .clk(clk), .rst_n(rst_n), .load_valid(lv[2]), .load_ready(lr[2]), .load_data(ld[2]),
    .confclk(cc[2]), .cbitin(ci[2]), .cbitout(co[2]), .rd_data(rd2), .done(dn[2]), .busy(bz[2]));
  always_comb begin
    rd[0] = {18'b0, rd0};
    rd[1] = {18'b0, rd1};
    rd[2] = rd2;
    for (int i = 0; i < NI; i++) co[i] = ch[i][nb(i)-1];
  end
  // the ycconfig chain: each confclk rise pushes cbitin in at the near end
  always @(posedge cc[0]) begin ch[0] = {ch[0][22:0], ci[0]}; rises[0]++; end
  always @(posedge cc[1]) begin ch[1] = {ch[1][22:0], ci[1]}; rises[1]++; end
  always @(posedge cc[2]) begin ch[2] = {ch[2][22:0], ci[2]}; rises[2]++; end
  initial forever #5 clk = ~clk;
  // transfer timeline: k = clk edges since acceptance (accept edge is 1), 0 when idle
  always @(posedge clk)
    for (int i = 0; i < NI; i++)
      if (!rst_n) begin
        k[i] = 0;
        exp_rd[i] = '0;
      end else if (k[i] == 0) begin
        if (lv[i]) begin
          k[i] = 1;
          img[i] = ld[i] & msk(i);
          old[i] = ch[i] & msk(i);
          rises[i] = 0;
        end
      end else if (k[i] == 2 * cd(i) * nb(i) + 1) k[i] = 0;
      else begin
        k[i]++;
        if (k[i] == 2 * cd(i) * nb(i) + 1) exp_rd[i] = old[i];
      end
  always @(negedge clk)
    if (rst_n)
      for (int i = 0; i < NI; i++) begin
        int t;
        t = 2 * cd(i) * nb(i);
        chk($sformatf("rd_data[%0d]", i), rd[i], exp_rd[i]);
        if (k[i] == 0) begin
          chk($sformatf("idle_ready[%0d]", i), 24'(lr[i]), 24'd1);
          chk($sformatf("idle_busy[%0d]", i), 24'(bz[i]), 24'd0);
          chk($sformatf("idle_done[%0d]", i), 24'(dn[i]), 24'd0);
          chk($sformatf("idle_confclk[%0d]", i), 24'(cc[i]), 24'd0);
        end else if (k[i] <= t) begin
          chk($sformatf("xfer_ready[%0d]", i), 24'(lr[i]), 24'd0);
          chk($sformatf("xfer_busy[%0d]", i), 24'(bz[i]), 24'd1);
          chk($sformatf("xfer_done[%0d]", i), 24'(dn[i]), 24'd0);
          chk($sformatf("xfer_confclk[%0d]", i), 24'(cc[i]), 24'(((k[i] - 1) / cd(i)) % 2));
          chk($sformatf("xfer_cbitin[%0d]", i), 24'(ci[i]),
              24'(img[i][nb(i) - 1 - (k[i] - 1) / (2 * cd(i))]));
        end else begin
          chk($sformatf("done_pulse[%0d]", i), 24'(dn[i]), 24'd1);
          chk($sformatf("done_busy[%0d]", i), 24'(bz[i]), 24'd1);
          chk($sformatf("done_confclk[%0d]", i), 24'(cc[i]), 24'd0);
          chk($sformatf("done_chain[%0d]", i), ch[i] & msk(i), img[i]);
          chk($sformatf("done_rises[%0d]", i), 24'(rises[i]), 24'(nb(i)));
        end
      end
  task automatic load(input int i, input logic [23:0] d, output int lat);
    int n = 0;
    @(negedge clk);
    lv[i] = 1'b1;
    ld[i] = d;
    while (!lr[i] && n < 500) begin @(negedge clk); n++; end
    @(negedge clk);
    lv[i] = 1'b0;
    lat = 1;
    while (!dn[i] && lat < 1000) begin @(negedge clk); lat++; end
  endtask
  initial begin
    int lat, n;
    logic [23:0] a;
    for (int i = 0; i < NI; i++) begin
      lv[i] = 1'b0; ld[i] = '0; ch[i] = '0; k[i] = 0; rises[i] = 0;
      img[i] = '0; old[i] = '0; exp_rd[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_rd", rd[2], 24'h0);
    chk("post_reset_ready", 24'(lr[2]), 24'd1);
    load(0, 24'b111_000, lat);
    chk("latency_c1", 24'(lat), 24'd13);
    chk("first_rd", rd[0], 24'h0);
    chk("far_cell_n", 24'(ch[0][5:3]), 24'(CFG_N));
    chk("near_cell_space", 24'(ch[0][2:0]), 24'(CFG_SPACE));
    load(0, 24'b100_101, lat);
    chk("second_rd", rd[0], 24'b111_000);
    chk("far_cell_one", 24'(ch[0][5:3]), 24'(CFG_ONE));
    chk("near_cell_zero", 24'(ch[0][2:0]), 24'(CFG_ZERO));
    load(1, 24'b101_010, lat);
    chk("latency_c3", 24'(lat), 24'd37);
    load(2, 24'h053977, lat);
    chk("latency_n8", 24'(lat), 24'd97);
    for (int c = 0; c < 8; c++)
      chk($sformatf("cell_code[%0d]", c), 24'(ch[2][23 - 3 * c -: 3]), 24'(c));
    load(2, 24'($urandom), lat);
    chk("reload_rd_n8", rd[2], 24'h053977);
    // held load_valid: second image accepted right after the idle cycle
    a = 24'($urandom) & 24'h3f;
    @(negedge clk);
    lv[0] = 1'b1;
    ld[0] = a;
    n = 0;
    while (!dn[0] && n < 200) begin @(negedge clk); n++; end
    chk("held_first_rd", rd[0], 24'b100_101);
    ld[0] = 24'($urandom);
    n = 0;
    do begin @(negedge clk); n++; end while (!bz[0] && n < 20);
    chk("held_gap", 24'(n), 24'd2);
    lv[0] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      lv[0] = ~lv[0];
      ld[0] = 24'($urandom);
    end
    lv[0] = 1'b0;
    n = 0;
    while (!dn[0] && n < 200) begin @(negedge clk); n++; end
    chk("held_second_rd", rd[0], a);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        lv[i] = $urandom_range(0, 3) == 0;
        ld[i] = 24'($urandom);
      end
      if (cyc == 1500) begin
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
          chk($sformatf("rst_confclk[%0d]", i), 24'(cc[i]), 24'd0);
          chk($sformatf("rst_cbitin[%0d]", i), 24'(ci[i]), 24'd0);
          chk($sformatf("rst_busy[%0d]", i), 24'(bz[i]), 24'd0);
          chk($sformatf("rst_done[%0d]", i), 24'(dn[i]), 24'd0);
          chk($sformatf("rst_rd[%0d]", i), rd[i], 24'h0);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) lv[i] = 1'b0;
    n = 0;
    while ((k[0] | k[1] | k[2]) != 0 && n < 400) begin @(negedge clk); n++; end
    chk("drain", 24'((k[0] | k[1] | k[2]) == 0), 24'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/yc_config_loader.md
Name: yc_config_loader

Overview:
- Host-side transmitter for the Morphle Logic serial configuration chain of ycconfig cells.
- Accepts one parallel configuration image: NCELLS cells, 3-bit code per cell.
- Shifts the image into the chain, MSB-first, driving a registered confclk/cbitin pair.
- Captures the previous image as it exits on cbitout, giving readback for free. Sits between the host register interface and the first ycconfig of a row/column chain.

Parameters:
NCELLS, 8, number of ycconfig cells in the chain; NBITS = 3*NCELLS
CDIV, 2, clk cycles per confclk phase (low and high each last CDIV cycles); legal range >= 1

Ports:
clk  input  1  system clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
load_valid  input  1  host offers load_data
load_ready  output  1  high only in IDLE; a transfer is accepted when load_valid && load_ready
load_data  input  NBITS  new image; [NBITS-1 -: 3] = farthest cell (sent first), [2:0] = cell nearest loader
confclk  output  1  chain shift clock, registered, glitch-free
cbitin  output  1  serial data into first cell, registered
cbitout  input  1  serial data from last cell of chain
rd_data  output  NBITS  previous image shifted out, same layout as load_data; valid when done=1
done  output  1  one-cycle pulse at end of transfer
busy  output  1  high from accept until done cycle inclusive

Behaviour:
- Reset, asynchronous on rst_n low: state=IDLE, confclk=0, cbitin=0, done=0, busy=0, load_ready=1 once released, rd_data=0, shift/capture registers=0, counters=0.
- States: IDLE, LOW, HIGH, DONE.
- IDLE:
  - On accept, latch load_data into tx shift register and clear bit counter.
  - Next cycle enter LOW with cbitin = load_data[NBITS-1].
- LOW, CDIV cycles:
  - confclk=0 and cbitin is stable.
  - In the last LOW cycle, sample cbitout into capture register LSB, shifting the capture left.
  - Then enter HIGH.
- HIGH, CDIV cycles:
  - confclk=1; the chain shifts on this rising edge.
  - cbitin is held for the whole high phase.
  - At the end of the phase: if bit counter = NBITS-1, go to DONE. Otherwise increment, shift tx left, go to LOW. cbitin takes the next bit on the same clk edge that confclk falls, giving a full phase of setup and hold.
- DONE, 1 cycle: confclk=0, done=1, rd_data = capture register, then IDLE.
- rd_data holds its value until the next DONE.
- Latency: accept edge to done pulse = 2*CDIV*NBITS + 1 clk cycles. Exactly NBITS confclk rising edges per transfer.
- Bit order: overall MSB-first. The first bit sent ends in the farthest cell's MSB stage; within each cell, bits go MSB-first.
- Readback: before the first rising edge, cbitout = old farthest-cell MSB. After NBITS samples, the capture register holds the old image in load_data layout.
- load_valid held high: a new transfer is accepted in the IDLE cycle after DONE. This gives back-to-back images with one idle cycle; confclk stays 0 in between.
- load_valid while busy: ignored, load_ready=0. load_data is sampled only at accept.
- Reset mid-transfer: confclk and cbitin drop to 0 immediately. Chain contents are undefined (partial shift) and the host must reload. No done pulse.
- confclk and cbitin come directly from flops, never from combinational decode.
- Counter widths: phase counter $clog2(CDIV+1), bit counter $clog2(NBITS+1).

Decomposition:
- Package yc_config_pkg:
  - CFG_BITS=3.
  - Cell codes: CFG_SPACE=3'b000, CFG_PLUS=3'b001, CFG_MINUS=3'b010, CFG_VBAR=3'b011, CFG_ONE=3'b100, CFG_ZERO=3'b101, CFG_Y=3'b110, CFG_N=3'b111.
  - State enum for the loader FSM.
- Sub-module yc_phase_timer: CDIV-cycle phase counter with start input and last-cycle output. It is reused by future chain readers.

Test Plan:
- Reset: assert rst_n=0 mid-run -> confclk=0, cbitin=0, busy=0, done=0 asynchronously. After release, load_ready=1 and rd_data=0.
- NCELLS=2, CDIV=1, two cascaded ycconfig, chain starts all-zero:
  - Load 6'b111_000 -> 6 confclk rising edges, done at cycle 13 after accept.
  - Far cell decodes N and near cell decodes space; rd_data=6'b000_000.
- Same chain, then load 6'b100_101 -> far cell=1, near cell=0, rd_data=6'b111_000.
- CDIV=3: check confclk low/high phases of exactly 3 cycles each. cbitin changes only on confclk falling-edge cycles. Accept-to-done = 37 cycles.
- load_valid held high across two images -> second accept in the cycle after done. load_valid pulses while busy are ignored with load_ready=0. Both rd_data values are correct.
- NCELLS=8: all eight codes CFG_SPACE..CFG_N in one image -> every cell decodes its code. A following reload returns the exact image on rd_data.
